// File: rtl/bwt_axil_pkg.sv
// bwt_axil_pkg: register map indices, response codes, FSM states and helpers for the AXI4-Lite slave
package bwt_axil_pkg;

    localparam logic [2:0] IDX_WR_COUNT = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    function automatic logic [1:0] write_resp(input logic [2:0] idx);
        return idx < IDX_WR_COUNT ? RESP_OKAY : idx == IDX_WR_COUNT ? RESP_SLVERR : RESP_DECERR;
    endfunction

    function automatic logic [1:0] read_resp(input logic [2:0] idx);
        return idx <= IDX_WR_COUNT ? RESP_OKAY : RESP_DECERR;
    endfunction

    function automatic logic [31:0] strb_merge(input logic [31:0] old, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
        return res;
    endfunction

endpackage

// File: rtl/bwt_axil_regbank.sv
// bwt_axil_regbank: four RW registers plus the accepted-write counter, strobe-merge write and combinational read
module bwt_axil_regbank
    import bwt_axil_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [1:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic [2:0]  raddr,
    output logic [31:0] rdata
);

    logic [31:0] regs [4];
    logic [31:0] wr_count;

    // every OKAY commit merges its byte lanes and bumps the counter, which wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            wr_count <= '0;
        end else if (we) begin
            regs[waddr] <= strb_merge(regs[waddr], wdata, wstrb);
            wr_count    <= wr_count + 32'd1;
        end
    end

    // unmapped word indices read as zero
    always_comb rdata = raddr[2] ? (raddr == IDX_WR_COUNT ? wr_count : '0) : regs[raddr[1:0]];

endmodule

// File: rtl/bwt_axil_slave.sv
// bwt_axil_slave: AXI4-Lite slave with four RW registers and a read-only write counter
module bwt_axil_slave
    import bwt_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    w_state_t    w_state, w_next;
    r_state_t    r_state, r_next;
    logic        active, aw_hold, w_hold;
    logic        aw_hs, w_hs, ar_hs, commit;
    logic [2:0]  aw_idx, w_idx;
    logic [31:0] wdata_q, w_data, rd_data;
    logic [3:0]  wstrb_q, w_strb;
    logic        unused_ok;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // readies stay low on the reset edge and rise on the first edge after reset is released
    always_ff @(posedge ACLK) active <= !ARESET;

    // state registers for both channel FSMs
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    // write channel: AW and W are taken independently; commit once both are in hand
    always_comb begin
        S_AXI_AWREADY = active && w_state == W_IDLE && !aw_hold;
        S_AXI_WREADY  = active && w_state == W_IDLE && !w_hold;
        S_AXI_BVALID  = w_state == W_RESP;
        aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
        w_hs   = S_AXI_WVALID && S_AXI_WREADY;
        commit = (aw_hold || aw_hs) && (w_hold || w_hs);
        w_idx  = aw_hold ? aw_idx : S_AXI_AWADDR[4:2];
        w_data = w_hold ? wdata_q : S_AXI_WDATA;
        w_strb = w_hold ? wstrb_q : S_AXI_WSTRB;
        w_next = w_state;
        if (w_state == W_IDLE && commit) w_next = W_RESP;
        else if (w_state == W_RESP && S_AXI_BREADY) w_next = W_IDLE;
    end

    // latch whichever half arrives first and register the response at commit
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_hold     <= 1'b0;
            w_hold      <= 1'b0;
            aw_idx      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            S_AXI_BRESP <= RESP_OKAY;
        end else if (commit) begin
            aw_hold     <= 1'b0;
            w_hold      <= 1'b0;
            S_AXI_BRESP <= write_resp(w_idx);
        end else begin
            if (aw_hs) begin
                aw_hold <= 1'b1;
                aw_idx  <= S_AXI_AWADDR[4:2];
            end
            if (w_hs) begin
                w_hold  <= 1'b1;
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
        end
    end

    // read channel: accept an address only while no data beat is pending
    always_comb begin
        S_AXI_ARREADY = active && r_state == R_IDLE;
        S_AXI_RVALID  = r_state == R_DATA;
        ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
        r_next = r_state;
        if (r_state == R_IDLE && ar_hs) r_next = R_DATA;
        else if (r_state == R_DATA && S_AXI_RREADY) r_next = R_IDLE;
    end

    // capture read data before any same-edge commit lands, so a colliding write is not visible
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            S_AXI_RDATA <= '0;
            S_AXI_RRESP <= RESP_OKAY;
        end else if (ar_hs) begin
            S_AXI_RDATA <= rd_data;
            S_AXI_RRESP <= read_resp(S_AXI_ARADDR[4:2]);
        end
    end

    bwt_axil_regbank u_regbank (
        .clk   (ACLK),
        .rst   (ARESET),
        .we    (commit && write_resp(w_idx) == RESP_OKAY),
        .waddr (w_idx[1:0]),
        .wdata (w_data),
        .wstrb (w_strb),
        .raddr (S_AXI_ARADDR[4:2]),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_bwt_axil_slave.sv
// tb_bwt_axil_slave: table vectors, corner-case sequences and random traffic against a register-map model
module tb_bwt_axil_slave;

    logic        clk = 0;
    logic        ARESET = 1;
    logic [4:0]  S_AXI_AWADDR = 0, S_AXI_ARADDR = 0;
    logic [2:0]  S_AXI_AWPROT = 0, S_AXI_ARPROT = 0;
    logic        S_AXI_AWVALID = 0, S_AXI_WVALID = 0, S_AXI_BREADY = 0, S_AXI_ARVALID = 0, S_AXI_RREADY = 0;
    logic [31:0] S_AXI_WDATA = 0;
    logic [3:0]  S_AXI_WSTRB = 0;
    logic        S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
    logic [31:0] S_AXI_RDATA;

    int passed = 0, total = 0;

    logic [31:0] m_regs [4];
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    bwt_axil_slave dut (
        .ACLK(clk), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 0;
        m_cnt = 0;
    endtask

    function automatic logic [1:0] model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int i = int'(a) / 4;
        if (i < 4) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) m_regs[i][8*b +: 8] = d[8*b +: 8];
            m_cnt = m_cnt + 1;
            return 2'b00;
        end
        return i == 4 ? 2'b10 : 2'b11;
    endfunction

    function automatic logic [33:0] model_read(input logic [4:0] a);
        int i = int'(a) / 4;
        if (i < 4) return {2'b00, m_regs[i]};
        if (i == 4) return {2'b00, m_cnt};
        return {2'b11, 32'h0};
    endfunction

    // all tasks start and end just after a falling edge
    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, b_done = 0;
        int c = 0;
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_BREADY = 1;
        resp = 2'bxx;
        while (!b_done && c < 100) begin
            S_AXI_AWVALID = !aw_done && c >= aw_dly;
            S_AXI_WVALID  = !w_done && c >= w_dly;
            #1;
            if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1;
            if (S_AXI_WVALID && S_AXI_WREADY) w_done = 1;
            if (S_AXI_BVALID) begin
                b_done = 1;
                resp = S_AXI_BRESP;
            end
            @(negedge clk);
            c++;
        end
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
        if (!b_done) check("write_timeout", 0, 1);
    endtask

    task automatic do_read(input logic [4:0] a, input int ar_dly, output logic [31:0] d, output logic [1:0] resp);
        bit ar_done = 0, r_done = 0;
        int c = 0;
        S_AXI_ARADDR = a; S_AXI_RREADY = 1;
        d = 'x; resp = 2'bxx;
        while (!r_done && c < 100) begin
            S_AXI_ARVALID = !ar_done && c >= ar_dly;
            #1;
            if (S_AXI_ARVALID && S_AXI_ARREADY) ar_done = 1;
            if (S_AXI_RVALID) begin
                r_done = 1;
                d = S_AXI_RDATA;
                resp = S_AXI_RRESP;
            end
            @(negedge clk);
            c++;
        end
        S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
        if (!r_done) check("read_timeout", 0, 1);
    endtask

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs [22];

    initial begin
        logic [31:0] rd, exp_d, old;
        logic [1:0]  rr, wr_r;
        logic [33:0] mr;
        int good;

        vecs = '{
            '{1, 5'h00, 32'h1, 4'hF, 32'h0, 2'b00},
            '{1, 5'h04, 32'h2, 4'hF, 32'h0, 2'b00},
            '{1, 5'h08, 32'h3, 4'hF, 32'h0, 2'b00},
            '{1, 5'h0C, 32'h4, 4'hF, 32'h0, 2'b00},
            '{0, 5'h00, 32'h0, 4'h0, 32'h1, 2'b00},
            '{0, 5'h04, 32'h0, 4'h0, 32'h2, 2'b00},
            '{0, 5'h08, 32'h0, 4'h0, 32'h3, 2'b00},
            '{0, 5'h0C, 32'h0, 4'h0, 32'h4, 2'b00},
            '{0, 5'h10, 32'h0, 4'h0, 32'h4, 2'b00},
            '{1, 5'h08, 32'hFFFFFFFF, 4'hF, 32'h0, 2'b00},
            '{1, 5'h08, 32'h12345678, 4'h5, 32'h0, 2'b00},
            '{0, 5'h08, 32'h0, 4'h0, 32'hFF34FF78, 2'b00},
            '{0, 5'h10, 32'h0, 4'h0, 32'h6, 2'b00},
            '{1, 5'h10, 32'hDEADBEEF, 4'hF, 32'h0, 2'b10},
            '{1, 5'h18, 32'hDEADBEEF, 4'hF, 32'h0, 2'b11},
            '{0, 5'h18, 32'h0, 4'h0, 32'h0, 2'b11},
            '{0, 5'h10, 32'h0, 4'h0, 32'h6, 2'b00},
            '{1, 5'h0D, 32'hCAFEF00D, 4'h0, 32'h0, 2'b00},
            '{0, 5'h0F, 32'h0, 4'h0, 32'h4, 2'b00},
            '{0, 5'h10, 32'h0, 4'h0, 32'h7, 2'b00},
            '{0, 5'h1C, 32'h0, 4'h0, 32'h0, 2'b11},
            '{0, 5'h14, 32'h0, 4'h0, 32'h0, 2'b11}
        };
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_awready", S_AXI_AWREADY, 0);
        check("rst_wready", S_AXI_WREADY, 0);
        check("rst_arready", S_AXI_ARREADY, 0);
        check("rst_bvalid", S_AXI_BVALID, 0);
        check("rst_rvalid", S_AXI_RVALID, 0);
        check("rst_rdata", S_AXI_RDATA, 0);
        check("rst_resps", {S_AXI_BRESP, S_AXI_RRESP}, 0);
        ARESET = 0;
        @(negedge clk);
        check("post_rst_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, wr_r);
                void'(model_write(vecs[i].addr, vecs[i].data, vecs[i].strb));
                check($sformatf("vec%0d_bresp", i), wr_r, vecs[i].exp_resp);
            end else begin
                do_read(vecs[i].addr, 0, rd, rr);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
                check($sformatf("vec%0d_rresp", i), rr, vecs[i].exp_resp);
            end
        end

        // W arrives three cycles ahead of AW
        S_AXI_WDATA = 32'hA5A5A5A5; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1; S_AXI_BREADY = 1;
        @(negedge clk);
        S_AXI_WVALID = 0;
        check("early_w_wready_low", S_AXI_WREADY, 0);
        good = 0;
        repeat (2) begin
            if (!S_AXI_BVALID && S_AXI_AWREADY) good++;
            @(negedge clk);
        end
        check("early_w_no_bvalid", good, 2);
        S_AXI_AWADDR = 5'h04; S_AXI_AWVALID = 1;
        @(negedge clk);
        S_AXI_AWVALID = 0;
        check("early_w_bvalid", S_AXI_BVALID, 1);
        check("early_w_bresp", S_AXI_BRESP, 0);
        @(negedge clk);
        check("early_w_single_b", S_AXI_BVALID, 0);
        S_AXI_BREADY = 0;
        void'(model_write(5'h04, 32'hA5A5A5A5, 4'hF));
        do_read(5'h04, 0, rd, rr);
        check("early_w_readback", rd, 32'hA5A5A5A5);
        do_read(5'h10, 0, rd, rr);
        check("early_w_count", rd, m_cnt);

        // read capture on the same edge as a write commit to the same register
        old = m_regs[0];
        S_AXI_AWADDR = 5'h00; S_AXI_WDATA = 32'h11112222; S_AXI_WSTRB = 4'hF;
        S_AXI_ARADDR = 5'h00; S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_ARVALID = 1;
        @(negedge clk);
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
        check("collide_rvalid_bvalid", {S_AXI_RVALID, S_AXI_BVALID}, 2'b11);
        check("collide_old_data", S_AXI_RDATA, old);
        S_AXI_BREADY = 1; S_AXI_RREADY = 1;
        @(negedge clk);
        check("collide_done", {S_AXI_RVALID, S_AXI_BVALID}, 2'b00);
        S_AXI_BREADY = 0; S_AXI_RREADY = 0;
        void'(model_write(5'h00, 32'h11112222, 4'hF));

        // back-pressure on B and R for ten cycles
        S_AXI_AWADDR = 5'h0C; S_AXI_WDATA = 32'h5A5A0FF0; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
        @(negedge clk);
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        void'(model_write(5'h0C, 32'h5A5A0FF0, 4'hF));
        good = 0;
        repeat (10) begin
            if (S_AXI_BVALID && S_AXI_BRESP == 2'b00 && !S_AXI_AWREADY && !S_AXI_WREADY) good++;
            @(negedge clk);
        end
        check("b_hold_cycles", good, 10);
        S_AXI_BREADY = 1;
        @(negedge clk);
        check("b_released", {S_AXI_BVALID, S_AXI_AWREADY}, 2'b01);
        S_AXI_BREADY = 0;
        S_AXI_ARADDR = 5'h0C; S_AXI_ARVALID = 1;
        @(negedge clk);
        S_AXI_ARVALID = 0;
        good = 0;
        repeat (10) begin
            if (S_AXI_RVALID && S_AXI_RDATA == 32'h5A5A0FF0 && S_AXI_RRESP == 2'b00 && !S_AXI_ARREADY) good++;
            @(negedge clk);
        end
        check("r_hold_cycles", good, 10);
        S_AXI_RREADY = 1;
        @(negedge clk);
        check("r_released", {S_AXI_RVALID, S_AXI_ARREADY}, 2'b01);
        S_AXI_RREADY = 0;

        // reset after AW latched but before W
        S_AXI_AWADDR = 5'h00; S_AXI_AWVALID = 1;
        @(negedge clk);
        S_AXI_AWVALID = 0;
        check("aw_only_readies", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b01);
        ARESET = 1;
        @(negedge clk);
        check("midrst_readies_low", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID}, 4'b0000);
        ARESET = 0;
        @(negedge clk);
        check("midrst_readies_high", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        model_reset();
        S_AXI_WDATA = 32'h0BADF00D; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1; S_AXI_BREADY = 1;
        @(negedge clk);
        S_AXI_WVALID = 0;
        good = 0;
        repeat (3) begin
            if (!S_AXI_BVALID) good++;
            @(negedge clk);
        end
        check("midrst_aw_discarded", good, 3);
        do_write(5'h18, 32'h0, 4'hF, 0, 0, wr_r);
        check("midrst_flush_resp", wr_r, 2'b11);
        for (int i = 0; i < 5; i++) begin
            do_read(5'(i * 4), 0, rd, rr);
            check($sformatf("midrst_reg%0d", i), rd, 0);
        end

        // random traffic against the model
        for (int n = 0; n < 80; n++) begin
            logic [4:0]  a;
            logic [31:0] d;
            logic [3:0]  s;
            a = 5'($urandom_range(0, 31));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), wr_r);
                check($sformatf("rnd%0d_bresp", n), wr_r, model_write(a, d, s));
            end else begin
                do_read(a, $urandom_range(0, 2), rd, rr);
                mr = model_read(a);
                exp_d = mr[31:0];
                check($sformatf("rnd%0d_rdata", n), rd, exp_d);
                check($sformatf("rnd%0d_rresp", n), rr, mr[33:32]);
            end
        end
        do_read(5'h10, 0, rd, rr);
        check("final_count", rd, m_cnt);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bwt_axil_slave.md
BWT_AXIL_SLAVE -- requirements
Module: bwt_axil_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, byte-address width.
REQ-003 SHALL have port ACLK, input, 1, the single clock; all logic rising-edge.
REQ-004 SHALL have port ARESET, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports S_AXI_AWADDR in [ADDR-1:0], S_AXI_AWPROT in 3 (ignored), S_AXI_AWVALID in 1, S_AXI_AWREADY out 1.
REQ-006 SHALL have ports S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1.
REQ-007 SHALL have ports S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1.
REQ-008 SHALL have ports S_AXI_ARADDR in [ADDR-1:0], S_AXI_ARPROT in 3 (ignored), S_AXI_ARVALID in 1, S_AXI_ARREADY out 1.
REQ-009 SHALL have ports S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1.

Function
REQ-010 SHALL map: 0x00-0x0C four RW regs REG0-REG3; 0x10 RO WR_COUNT (accepted OKAY writes, 32-bit, wraps at 2^32-1 -> 0); 0x14-0x1C unmapped.
REQ-011 SHALL decode word address ADDR[4:2]; ADDR[1:0] ignored.
REQ-012 Write FSM SHALL have states W_IDLE, W_RESP.
REQ-013 In W_IDLE, SHALL accept AW and W independently: AWREADY high while no AW latched, WREADY high while no W latched; each handshake latches its channel.
REQ-014 SHALL commit write in the cycle both AW and W are latched (or handshake same cycle), set BVALID next cycle, go W_RESP.
REQ-015 Commit SHALL update only byte lanes with WSTRB set; WSTRB=0 leaves register unchanged but still responds OKAY and increments WR_COUNT.
REQ-016 Writes to 0x10 SHALL leave WR_COUNT unchanged, respond SLVERR (2'b10), not increment; writes to unmapped SHALL respond DECERR (2'b11), not increment.
REQ-017 In W_RESP, AWREADY=WREADY=0; BVALID/BRESP SHALL hold stable until BREADY; on handshake -> W_IDLE, ready for new AW/W next cycle.
REQ-018 Read FSM SHALL have states R_IDLE, R_DATA; ARREADY=1 only in R_IDLE.
REQ-019 On AR handshake, SHALL register RDATA/RRESP, assert RVALID next cycle (1-cycle latency), go R_DATA.
REQ-020 RDATA/RRESP SHALL hold stable until RREADY; on handshake -> R_IDLE.
REQ-021 Unmapped reads SHALL return RDATA=0, RRESP=DECERR; mapped reads OKAY.
REQ-022 Read capture and write commit to same register in same cycle SHALL return pre-write value.
REQ-023 Read and write channels SHALL operate concurrently; at most one outstanding transaction per channel.

Reset
REQ-024 While ARESET=1 at a clock edge: REG0-3=0, WR_COUNT=0, both FSMs idle, latched AW/W cleared, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, AWREADY=WREADY=ARREADY=0.
REQ-025 First edge after ARESET falls SHALL drive AWREADY=WREADY=ARREADY=1.
REQ-026 Reset mid-transaction SHALL abandon it without a response; partially latched AW/W discarded.

Structure
REQ-027 Package bwt_axil_pkg SHALL hold register offsets, resp codes (OKAY/SLVERR/DECERR), state enums.
REQ-028 One sub-module bwt_axil_regbank SHALL hold REG0-3 and WR_COUNT, with strobe-merge write port and combinational read port.

Verification
REQ-029 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, read back -> data equal, all OKAY, 0x10 reads 4.
REQ-030 W presented 3 cycles before AW to 0x4, 0xA5A5A5A5 -> single commit when AW arrives, BVALID next cycle, read 0xA5A5A5A5.
REQ-031 Write 0xFFFFFFFF then 0x12345678 with WSTRB=4'b0101 to 0x8 -> read 0xFF34FF78.
REQ-032 Write 0x10 and 0x18; read 0x18 -> SLVERR, DECERR, RDATA=0, WR_COUNT unchanged.
REQ-033 BREADY/RREADY held low 10 cycles -> BVALID/RVALID, BRESP/RDATA stable, AWREADY/ARREADY low throughout.
REQ-034 ARESET pulsed after AW latched before W -> no BVALID, all regs 0, readies high after reset.
